// File: rtl/lfsr_value_gen_pkg.sv
// Shared definitions for the LFSR value generator.
//   gen_state_e        : run/pause controller state
//   LFSR_WIDTH         : LFSR width used by the display path
//   LFSR_TAPS_16       : feedback mask, x^16+x^14+x^13+x^11
//   LFSR_DEFAULT_SEED  : reset state, also used in place of an all-zero seed
package lfsr_value_gen_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_PAUSED = 1'b1
   } gen_state_e;

   localparam int          LFSR_WIDTH        = 16;
   localparam logic [15:0] LFSR_TAPS_16      = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_value_gen_if.sv
// Seed handshake and value stream between the generator and its neighbours.
//   seed_valid / seed_data / seed_ready : seed offer and acceptance
//   value       : {paused flag, LFSR state}
//   value_valid : one-cycle pulse when the LFSR state changes
//   step_count  : steps since reset or last seed load
// master = seed source / value consumer, slave = generator.
interface lfsr_value_gen_if
   import lfsr_value_gen_pkg::*;
#(
   parameter int WIDTH = LFSR_WIDTH
);
   logic             seed_valid;
   logic [WIDTH-1:0] seed_data;
   logic             seed_ready;
   logic [WIDTH:0]   value;
   logic             value_valid;
   logic [15:0]      step_count;

   modport master (
      output seed_valid, seed_data,
      input  seed_ready, value, value_valid, step_count
   );

   modport slave (
      input  seed_valid, seed_data,
      output seed_ready, value, value_valid, step_count
   );
endinterface

// File: rtl/lfsr_value_gen_tick_prescaler.sv
// Step-rate prescaler: one-cycle tick every PRESCALE enabled cycles.
//   clk   : clock
//   clear : synchronous restart of the period (reset or seed load)
//   en    : count enable; the count holds while low
//   tick  : high in the last cycle of each period
// Implemented as a down-counter holding the cycles left in the period, so
// the terminal-count compare is against zero.
module tick_prescaler #(
   parameter int PRESCALE = 50_000_000
) (
   input  logic clk,
   input  logic clear,
   input  logic en,
   output logic tick
);
   localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q <= LOAD;
      end else if (en) begin
         if (cnt_q == '0) cnt_q <= LOAD;
         else             cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/lfsr_value_gen.sv
// Prescaled 16-bit Fibonacci LFSR feeding the seven-segment multiplexer.
//   clk, reset : clock, synchronous active-high reset
//   toggle     : level, high pauses automatic stepping
//   step_req   : single-step pulse, honoured only while paused
//   bus        : seed handshake and value/value_valid/step_count outputs
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | prescaler counting, LFSR steps on each tick
// ST_PAUSED | prescaler frozen, LFSR steps only on step_req
module lfsr_value_gen
   import lfsr_value_gen_pkg::*;
#(
   parameter int               WIDTH        = LFSR_WIDTH,
   parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS_16,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
   parameter int               PRESCALE     = 50_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 toggle,
   input  logic                 step_req,
   lfsr_value_gen_if.slave      bus
);
   gen_state_e       state_q;
   logic             paused_q;
   logic [WIDTH-1:0] lfsr_q;
   logic             value_valid_q;
   logic [15:0]      step_count_q;

   logic             seed_xfer;
   logic [WIDTH-1:0] seed_word;
   logic [WIDTH-1:0] lfsr_next;
   logic             tick;
   logic             do_step;

   assign bus.seed_ready = !reset;
   assign seed_xfer      = bus.seed_valid && !reset;
   assign seed_word      = (bus.seed_data == '0) ? DEFAULT_SEED : bus.seed_data;
   assign lfsr_next      = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .clear (reset || seed_xfer),
      .en    (state_q == ST_RUN),
      .tick  (tick)
   );

   // A seed load wins over any step in the same cycle; the step is lost.
   assign do_step = !seed_xfer &&
                    (tick || ((state_q == ST_PAUSED) && step_req));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         paused_q <= 1'b0;
      end else begin
         state_q  <= toggle ? ST_PAUSED : ST_RUN;
         paused_q <= toggle;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q        <= DEFAULT_SEED;
         step_count_q  <= '0;
         value_valid_q <= 1'b0;
      end else begin
         value_valid_q <= 1'b0;
         if (seed_xfer) begin
            lfsr_q        <= seed_word;
            step_count_q  <= '0;
            value_valid_q <= (seed_word != lfsr_q);
         end else if (do_step) begin
            lfsr_q        <= lfsr_next;
            step_count_q  <= step_count_q + 16'd1;
            value_valid_q <= 1'b1;
         end
      end
   end

   assign bus.value       = {paused_q, lfsr_q};
   assign bus.value_valid = value_valid_q;
   assign bus.step_count  = step_count_q;

endmodule
